seg7_scan_display: RTL

//  Consumer of the clock core's BCD time/day outputs. Drives a 6-digit multiplexed 7-segment display.

---
 rtl/seg7_scan_display_pkg.sv | 36 +++
 rtl/seg7_scan_display_bcd_to_seg7.sv | 26 ++
 rtl/seg7_scan_display.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Segment glyphs and the per-frame input snapshot shared by the scan display.
// Glyphs are 7-bit {g,f,e,d,c,b,a}, active-low; the decimal point is added by the top.
package seg7_scan_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef struct packed {
    logic [3:0] hour_h;
    logic [3:0] hour_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
    logic [2:0] day;
    logic       disp_day;
    logic       adj_day;
    logic       adj_hour;
    logic       adj_min;
  } snap_t;

endpackage

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// BCD digit to active-low 7-segment glyph; non-decimal codes render as 'E'.
// Purely combinational, no backpressure.
module bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// 6-digit multiplexed 7-segment driver: time HH.MM.SS or day "d-   N", frame snapshot, dead-time, field blink.
// Outputs registered one cycle behind the scan counters; free-running, no backpressure.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int DEAD_CYC = 64,
  parameter int BLINK_HZ = 2
) (
  input  logic       CLK,
  input  logic       Rstn,
  input  logic [3:0] SecH,
  input  logic [3:0] SecL,
  input  logic [3:0] MinH,
  input  logic [3:0] MinL,
  input  logic [3:0] HourH,
  input  logic [3:0] HourL,
  input  logic [2:0] Day,
  input  logic       DispDay,
  input  logic       AdjustDay,
  input  logic       AdjustHour,
  input  logic       AdjustMin,
  output logic [7:0] SEG_n,
  output logic [5:0] DIG_n
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD       = CW'(DEAD_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blank_q, blank_d;
  snap_t         snap_q, snap_d;
  logic [7:0]    seg_q, seg_d;
  logic [5:0]    dig_q, dig_d;

  logic          slot_end;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [6:0]    glyph;
  logic          dp_n;
  logic          blink;

  assign slot_end = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    bcnt_d  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
    blank_d = (bcnt_q == BLINK_LAST) ? ~blank_q : blank_q;
    // Latch at the very end of the frame so all six digits come from one coherent sample.
    snap_d  = snap_q;
    if (slot_end && idx_q == LAST_IDX) begin
      snap_d.hour_h   = HourH;
      snap_d.hour_l   = HourL;
      snap_d.min_h    = MinH;
      snap_d.min_l    = MinL;
      snap_d.sec_h    = SecH;
      snap_d.sec_l    = SecL;
      snap_d.day      = Day;
      snap_d.disp_day = DispDay;
      snap_d.adj_day  = AdjustDay;
      snap_d.adj_hour = AdjustHour;
      snap_d.adj_min  = AdjustMin;
    end
  end

  always_comb begin
    case (idx_q)
      3'd0:    nib = snap_q.sec_l;
      3'd1:    nib = snap_q.sec_h;
      3'd2:    nib = snap_q.min_l;
      3'd3:    nib = snap_q.min_h;
      3'd4:    nib = snap_q.hour_l;
      3'd5:    nib = snap_q.hour_h;
      default: nib = 4'd0;
    endcase
    if (snap_q.disp_day) nib = {1'b0, snap_q.day};
  end

  bcd_to_seg7 u_dec (
    .bcd_i   (nib),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    glyph = dec_seg;
    dp_n  = 1'b1;
    blink = 1'b0;
    if (snap_q.disp_day) begin
      case (idx_q)
        3'd5:    glyph = SEG_D;
        3'd4:    glyph = SEG_DASH;
        3'd0:    glyph = dec_seg;
        default: glyph = SEG_BLANK;
      endcase
      blink = snap_q.adj_day && (idx_q == 3'd0);
    end else begin
      dp_n  = !(idx_q == 3'd2 || idx_q == 3'd4);
      blink = (snap_q.adj_hour && idx_q >= 3'd4) ||
              (snap_q.adj_min && (idx_q == 3'd2 || idx_q == 3'd3));
    end

    // Dead-time at slot start lets the previous digit's drivers turn off before the next one lights.
    if (cnt_q < DEAD) begin
      seg_d = 8'hFF;
      dig_d = 6'h3F;
    end else begin
      dig_d = ~(6'b1 << idx_q);
      seg_d = (blink && blank_q) ? 8'hFF : {dp_n, glyph};
    end
  end

  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      bcnt_q  <= '0;
      blank_q <= 1'b0;
      snap_q  <= '0;
      seg_q   <= 8'hFF;
      dig_q   <= 6'h3F;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign SEG_n = seg_q;
  assign DIG_n = dig_q;

endmodule
